accumulate: RTL

//   Downstream stage of the fixed-point multiplier: sums N consecutive signed
//   Q-format products into one dot-product term (e.g. a neuron pre-activation).

---
 rtl/accumulate_pkg.sv | 19 +
 rtl/accumulate_if.sv | 11 +
 rtl/accumulate_saturate.sv | 22 ++
 rtl/accumulate.sv | 81 ++++++++
 4 files changed

// File: rtl/accumulate_pkg.sv
// Shared fixed-point constants for the accumulate stage and the activation stage.
// The signed W-bit bounds are functions of width so every stage derives them the same way.
package accumulate_pkg;

    localparam int W_DEF = 16;
    localparam int Q_DEF = 8;
    localparam int N_DEF = 4;

    // Largest positive value representable in a w-bit two's-complement word.
    function automatic longint sat_max(input int w);
        return (64'sd1 <<< (w - 1)) - 64'sd1;
    endfunction

    // Most negative value representable in a w-bit two's-complement word.
    function automatic longint sat_min(input int w);
        return -(64'sd1 <<< (w - 1));
    endfunction

endpackage

// File: rtl/accumulate_if.sv
// Valid/ready stream: stb qualifies dat, the beat transfers on stb & rdy.
interface accumulate_if #(
    parameter int DW = 16
);
    logic          stb;
    logic [DW-1:0] dat;
    logic          rdy;

    modport master (output stb, output dat, input  rdy);
    modport slave  (input  stb, input  dat, output rdy);
endinterface

// File: rtl/accumulate_saturate.sv
// Combinational signed clamp of an I-bit value into an O-bit signed word.
// Fractional alignment is untouched; only the integer range is limited.
module saturate
    import accumulate_pkg::*;
#(
    parameter int I = 27,
    parameter int O = 16
) (
    input  logic signed [I-1:0] x_i,
    output logic        [O-1:0] y_o
);
    localparam logic signed [I-1:0] MAX = I'(sat_max(O));
    localparam logic signed [I-1:0] MIN = I'(sat_min(O));

    always_comb begin
        y_o = x_i[O-1:0];
        if (x_i > MAX)
            y_o = MAX[O-1:0];
        else if (x_i < MIN)
            y_o = MIN[O-1:0];
    end
endmodule

// File: rtl/accumulate.sv
// Sums N consecutive signed Q-format products and emits the saturated W-bit sum.
// The next batch keeps accumulating while a finished result waits downstream.
module accumulate
    import accumulate_pkg::*;
#(
    parameter int W = W_DEF,
    parameter int Q = Q_DEF,
    parameter int N = N_DEF
) (
    input  logic         clk,
    input  logic         rst,
    accumulate_if.slave  arg_i,
    accumulate_if.master res_o
);
    localparam int P  = 2*W - Q;
    localparam int AW = P + $clog2(N) + 1;
    localparam int CW = (N > 1) ? $clog2(N) : 1;

    generate
        if (Q < 1 || Q > W || N < 1) begin : g_param_err
            $fatal(1, "ERROR: accumulate needs 1 <= Q <= W and N >= 1");
        end
    endgenerate

    logic [CW-1:0]        count_q, count_d;
    logic signed [AW-1:0] acc_q, acc_d;
    logic signed [AW-1:0] arg_ext, acc_next;
    logic [W-1:0]         res_dat_q, res_dat_d, sat_w;
    logic                 res_stb_q, res_stb_d;
    logic                 last, arg_rdy, arg_ack, res_ack;

    assign last     = (count_q == CW'(N - 1));
    assign arg_rdy  = ~last | ~res_stb_q | res_o.rdy;
    assign arg_ack  = arg_i.stb & arg_rdy;
    assign res_ack  = res_stb_q & res_o.rdy;

    assign arg_ext  = {{(AW-P){arg_i.dat[P-1]}}, arg_i.dat};
    // First product of a batch overwrites, so no separate clear cycle is needed.
    assign acc_next = (count_q == '0) ? arg_ext : acc_q + arg_ext;

    saturate #(.I(AW), .O(W)) u_sat (
        .x_i (acc_next),
        .y_o (sat_w)
    );

    always_comb begin
        count_d   = count_q;
        acc_d     = acc_q;
        res_dat_d = res_dat_q;
        res_stb_d = res_stb_q;
        if (arg_ack) begin
            acc_d   = acc_next;
            count_d = last ? '0 : count_q + 1'b1;
        end
        // A new result takes priority over the consume, keeping stb high with no bubble.
        if (arg_ack && last) begin
            res_dat_d = sat_w;
            res_stb_d = 1'b1;
        end else if (res_ack) begin
            res_stb_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            count_q   <= '0;
            acc_q     <= '0;
            res_dat_q <= '0;
            res_stb_q <= 1'b0;
        end else begin
            count_q   <= count_d;
            acc_q     <= acc_d;
            res_dat_q <= res_dat_d;
            res_stb_q <= res_stb_d;
        end
    end

    assign arg_i.rdy = arg_rdy;
    assign res_o.stb = res_stb_q;
    assign res_o.dat = res_dat_q;
endmodule
